popcount_accumulator: RTL and testbench
=======================================

# popcount_accumulator

Sequential XNOR-popcount accumulator for binarized NTM datapaths: consumes a stream of bitwise-match words produced by the upstream `xnor_gate` stage and counts their set bits over a programmable number of words. It produces either the total match count or, when configured, the signed binary dot product. The result feeds the downstream vector/scalar arithmetic stages. One word is accepted per cycle under a START/READY transaction handshake.

## Interface
- `DATA_SIZE`, 64, width of input words and of `DATA_OUT`
- `CONTROL_SIZE`, 64, width of `LENGTH_IN` (word count per transaction)

- `CLK`  input  1  clock; all state updates on rising edge
- `RST`  input  1  reset; synchronous, active-high
- `START`  input  1  begins a transaction; sampled only in `STARTER_STATE`
- `LENGTH_IN`  input  `CONTROL_SIZE`  number of words in the transaction; latched with `START`
- `DATA_IN_ENABLE`  input  1  qualifies `DATA_IN` as a valid word
- `DATA_IN`  input  `DATA_SIZE`  match word (XNOR result)
- `READY`  output  1  one-cycle pulse: `DATA_OUT` holds a new result
- `DATA_OUT`  output  `DATA_SIZE`  result; holds until the next result or reset

## Operation
- FSM states:
  - `STARTER_STATE` (idle)
  - `INPUT_STATE` (accumulating)
  - `ENDER_STATE` (final transform and publish)
- Reset (`RST`=1 at an edge): state ← `STARTER_STATE`, accumulator ← 0, word counter ← 0, `READY` ← 0, `DATA_OUT` ← 0. Reset overrides every other input, including mid-transaction; the partial sum is discarded.
- `STARTER_STATE`, `START`=1:
  - Latch `LENGTH_IN` and clear the accumulator and counter.
  - Next state is `INPUT_STATE`, or `ENDER_STATE` if `LENGTH_IN`=0.
  - `DATA_IN_ENABLE` is ignored in this state, even in the same cycle as `START`.
- `INPUT_STATE`, `DATA_IN_ENABLE`=1:
  - accumulator ← accumulator + popcount(`DATA_IN`); counter ← counter + 1.
  - When counter+1 equals the latched length, next state is `ENDER_STATE`.
  - Idle cycles (`DATA_IN_ENABLE`=0) are allowed anywhere and hold all state.
- `ENDER_STATE`: `DATA_OUT` ← transform(accumulator), `READY` ← 1, next state `STARTER_STATE`.
- `READY` is 1 for exactly one cycle and deasserts on the following edge.
- `START` outside `STARTER_STATE` is ignored. A `START` in the cycle `READY` is high is accepted, because the FSM is already in `STARTER_STATE`.
- popcount: combinational count of ones in `DATA_IN`, range 0..`DATA_SIZE`, zero-extended to `DATA_SIZE`.
- Accumulator is `DATA_SIZE` bits and wraps modulo 2^`DATA_SIZE`. No saturation and no overflow flag.
- Word counter is `CONTROL_SIZE` bits.

## Timing
- Throughput: one word per cycle.
- Latency: last word accepted at edge k → `ENDER_STATE` during cycle k..k+1 → `READY`=1 and `DATA_OUT` valid after edge k+1.
- `LENGTH_IN`=0: `START` at edge k → `READY` after edge k+1, `DATA_OUT`=transform(0).
- Minimum transaction period: `LENGTH_IN`+2 cycles. Back-to-back transactions are possible when `START` is asserted while `READY` is high.
- `LENGTH_IN` and `DATA_IN` need only be stable at the edge where they are sampled.

## Configuration
- Macro `POPCOUNT_ACCUMULATOR_BINARY_DOT_EN`.
- Undefined: transform(acc) = acc, i.e. the raw match count.
- Defined: transform(acc) = 2·acc − length·`DATA_SIZE`, computed in `ENDER_STATE`.
  - This is the ±1 binary dot product, two's complement, truncated to `DATA_SIZE` bits.
  - The multiply uses the latched length. `DATA_SIZE` must be a power of two, so the multiply reduces to a shift.
  - With length 0 the result is 0.

## Test plan
- `DATA_SIZE`=8, `LENGTH_IN`=3, words 0xFF, 0x0F, 0x01 on consecutive cycles → `DATA_OUT`=13, `READY` one cycle, exactly one edge after the third word is accepted.
- Same stream with `DATA_IN_ENABLE` low for 2 cycles between words, plus an ignored 0xFF driven while enable is low → `DATA_OUT`=13. `START` pulsed during `INPUT_STATE` has no effect.
- `LENGTH_IN`=0 → `READY` after 2 edges from the `START` sample, `DATA_OUT`=0 in both configurations. `START` and `DATA_IN_ENABLE` with 0xFF in the same idle cycle, `LENGTH_IN`=1, then 0x03 → `DATA_OUT`=2.
- `RST` asserted after 1 of 3 words (0xFF) → `READY`=0, `DATA_OUT`=0 next cycle. New transaction `LENGTH_IN`=1, word 0x03 → `DATA_OUT`=2, proving the partial sum was discarded.
- Back-to-back: `START` with `LENGTH_IN`=1 asserted in the `READY` cycle of the previous result (13), word 0x80 → second `READY` with `DATA_OUT`=1, previous value held until then. Accumulator wrap: 33 words of 0xFF → `DATA_OUT`=264 mod 256=8.
- `POPCOUNT_ACCUMULATOR_BINARY_DOT_EN` defined, `DATA_SIZE`=8:
  - 0xFF, 0x00 → `DATA_OUT`=0x00
  - 0xFF, 0xFF → 0x10 (16)
  - 0x00, 0x00 → 0xF0 (−16)

Source files
------------

// File: rtl/popcount_accumulator.sv
// ============================================================================
// Module   : popcount_accumulator
// Purpose  : Sequential XNOR-popcount accumulator over a programmable word
//            count. The build macro POPCOUNT_ACCUMULATOR_BINARY_DOT_EN selects
//            the signed +/-1 dot-product output instead of the raw match count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_accumulator #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic                    READY,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    localparam logic [1:0] STARTER_STATE = 2'd0;
    localparam logic [1:0] INPUT_STATE   = 2'd1;
    localparam logic [1:0] ENDER_STATE   = 2'd2;

    logic [1:0]              r_state;
    logic [DATA_SIZE-1:0]    r_acc;
    logic [CONTROL_SIZE-1:0] r_cnt;
    logic [CONTROL_SIZE-1:0] r_len;
    logic                    r_ready;
    logic [DATA_SIZE-1:0]    r_data_out;

    logic [DATA_SIZE-1:0]    w_pop;
    logic [CONTROL_SIZE-1:0] w_cnt_next;
    logic                    w_last;
    logic [DATA_SIZE-1:0]    w_result;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            w_pop = w_pop + DATA_SIZE'(DATA_IN[i]);
        end
    end

    assign w_cnt_next = r_cnt + CONTROL_SIZE'(1);
    assign w_last     = (w_cnt_next == r_len);

`ifdef POPCOUNT_ACCUMULATOR_BINARY_DOT_EN
    localparam int LOG2_DS = $clog2(DATA_SIZE);
    logic [DATA_SIZE-1:0] w_len_ds;

    // DATA_SIZE is a power of two, so length*DATA_SIZE is a plain shift.
    assign w_len_ds = DATA_SIZE'(r_len);
    assign w_result = (r_acc << 1) - (w_len_ds << LOG2_DS);
`else
    assign w_result = r_acc;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= STARTER_STATE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                STARTER_STATE: begin
                    if (START) begin
                        r_len   <= LENGTH_IN;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= (LENGTH_IN == '0) ? ENDER_STATE : INPUT_STATE;
                    end
                end
                INPUT_STATE: begin
                    if (DATA_IN_ENABLE) begin
                        r_acc <= r_acc + w_pop;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            r_state <= ENDER_STATE;
                        end
                    end
                end
                ENDER_STATE: begin
                    r_data_out <= w_result;
                    r_ready    <= 1'b1;
                    r_state    <= STARTER_STATE;
                end
                default: r_state <= STARTER_STATE;
            endcase
        end
    end

    assign READY    = r_ready;
    assign DATA_OUT = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_popcount_accumulator.sv
// ============================================================================
// Module   : tb_popcount_accumulator
// Purpose  : Directed self-checking bench for popcount_accumulator (DATA_SIZE=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_popcount_accumulator;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] LENGTH_IN;
    logic       DATA_IN_ENABLE;
    logic [7:0] DATA_IN;
    logic       READY;
    logic [7:0] DATA_OUT;

    int checks   = 0;
    int failures = 0;

    // Expected results: raw count, or 2*acc - len*8 in the dot-product build.
`ifdef POPCOUNT_ACCUMULATOR_BINARY_DOT_EN
    localparam logic [7:0] EXP_FF0F01 = 8'd2;
    localparam logic [7:0] EXP_03     = 8'hFC;
    localparam logic [7:0] EXP_80     = 8'hFA;
    localparam logic [7:0] EXP_WRAP   = 8'd8;
    localparam logic [7:0] EXP_FF00   = 8'h00;
    localparam logic [7:0] EXP_FFFF   = 8'h10;
    localparam logic [7:0] EXP_0000   = 8'hF0;
`else
    localparam logic [7:0] EXP_FF0F01 = 8'd13;
    localparam logic [7:0] EXP_03     = 8'd2;
    localparam logic [7:0] EXP_80     = 8'd1;
    localparam logic [7:0] EXP_WRAP   = 8'd8;
    localparam logic [7:0] EXP_FF00   = 8'd8;
    localparam logic [7:0] EXP_FFFF   = 8'd16;
    localparam logic [7:0] EXP_0000   = 8'd0;
`endif

    popcount_accumulator #(
        .DATA_SIZE    (8),
        .CONTROL_SIZE (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .LENGTH_IN      (LENGTH_IN),
        .DATA_IN_ENABLE (DATA_IN_ENABLE),
        .DATA_IN        (DATA_IN),
        .READY          (READY),
        .DATA_OUT       (DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_txn(input logic [7:0] len);
        START     = 1'b1;
        LENGTH_IN = len;
        tick();
        START = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = w;
        tick();
        DATA_IN_ENABLE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", READY);
        end
        checks++;
        if (DATA_OUT !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got %0d expected 0", DATA_OUT);
        end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        start_txn(8'd3);
        send_word(8'hFF);
        send_word(8'h0F);
        send_word(8'h01);
        checks++;
        if (READY !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_ready: got %b expected 0", READY);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_FF0F01) begin
            failures++;
            $display("FAIL basic_result: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_FF0F01);
        end
        tick();
        checks++;
        if (READY !== 1'b0 || DATA_OUT !== EXP_FF0F01) begin
            failures++;
            $display("FAIL basic_pulse_hold: got ready=%b data=%0d expected ready=0 data=%0d",
                     READY, DATA_OUT, EXP_FF0F01);
        end
    endtask

    task automatic test_idle_gaps();
        int n;
        start_txn(8'd3);
        send_word(8'hFF);
        DATA_IN = 8'hFF;
        START   = 1'b1;
        tick();
        START = 1'b0;
        tick();
        send_word(8'h0F);
        tick();
        tick();
        send_word(8'h01);
        n = 0;
        while (READY !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL gaps_latency: got %0d cycles expected 1", n);
        end
        checks++;
        if (DATA_OUT !== EXP_FF0F01) begin
            failures++;
            $display("FAIL gaps_result: got %0d expected %0d", DATA_OUT, EXP_FF0F01);
        end
        tick();
    endtask

    task automatic test_len_zero();
        start_txn(8'd0);
        checks++;
        if (READY !== 1'b0) begin
            failures++;
            $display("FAIL len0_early_ready: got %b expected 0", READY);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== 8'd0) begin
            failures++;
            $display("FAIL len0_result: got ready=%b data=%0d expected ready=1 data=0",
                     READY, DATA_OUT);
        end
        tick();
        // Enable in the START cycle must not count the 0xFF word.
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = 8'hFF;
        start_txn(8'd1);
        send_word(8'h03);
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_03) begin
            failures++;
            $display("FAIL start_enable_result: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_03);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_txn(8'd3);
        send_word(8'hFF);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (READY !== 1'b0 || DATA_OUT !== 8'd0) begin
            failures++;
            $display("FAIL midreset_clear: got ready=%b data=%0d expected ready=0 data=0",
                     READY, DATA_OUT);
        end
        start_txn(8'd1);
        send_word(8'h03);
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_03) begin
            failures++;
            $display("FAIL midreset_after: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_03);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start_txn(8'd3);
        send_word(8'hFF);
        send_word(8'h0F);
        send_word(8'h01);
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_FF0F01) begin
            failures++;
            $display("FAIL b2b_first: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_FF0F01);
        end
        start_txn(8'd1);
        send_word(8'h80);
        checks++;
        if (READY !== 1'b0 || DATA_OUT !== EXP_FF0F01) begin
            failures++;
            $display("FAIL b2b_hold: got ready=%b data=%0d expected ready=0 data=%0d",
                     READY, DATA_OUT, EXP_FF0F01);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_80) begin
            failures++;
            $display("FAIL b2b_second: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_80);
        end
        tick();
    endtask

    task automatic test_wrap();
        start_txn(8'd33);
        for (int i = 0; i < 33; i++) begin
            send_word(8'hFF);
        end
        tick();
        checks++;
        if (READY !== 1'b1 || DATA_OUT !== EXP_WRAP) begin
            failures++;
            $display("FAIL wrap_result: got ready=%b data=%0d expected ready=1 data=%0d",
                     READY, DATA_OUT, EXP_WRAP);
        end
        tick();
    endtask

    task automatic test_two_word_patterns();
        logic [7:0] w0 [3];
        logic [7:0] w1 [3];
        logic [7:0] ex [3];
        w0 = '{8'hFF, 8'hFF, 8'h00};
        w1 = '{8'h00, 8'hFF, 8'h00};
        ex = '{EXP_FF00, EXP_FFFF, EXP_0000};
        for (int p = 0; p < 3; p++) begin
            start_txn(8'd2);
            send_word(w0[p]);
            send_word(w1[p]);
            tick();
            checks++;
            if (READY !== 1'b1 || DATA_OUT !== ex[p]) begin
                failures++;
                $display("FAIL pattern_%0d: got ready=%b data=%0h expected ready=1 data=%0h",
                         p, READY, DATA_OUT, ex[p]);
            end
            tick();
        end
    endtask

    initial begin
        RST            = 1'b1;
        START          = 1'b0;
        LENGTH_IN      = 8'd0;
        DATA_IN_ENABLE = 1'b0;
        DATA_IN        = 8'd0;
        test_reset();
        test_basic();
        test_idle_gaps();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        test_two_word_patterns();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
